// File: rtl/alarm_chime_pkg.sv
// Shared definitions for the alarm chime controller: FSM encoding and default timing.
package alarm_chime_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StBeepOn  = 2'd1,
      StBeepOff = 2'd2,
      StHold    = 2'd3
   } chime_state_e;

   localparam int unsigned DefDebounceCyc = 4;
   localparam int unsigned DefBeepOnCyc   = 8;
   localparam int unsigned DefBeepOffCyc  = 8;
   localparam int unsigned DefMaxBeeps    = 3;
   localparam int unsigned DefCntW        = 16;

endpackage

// File: rtl/alarm_chime_ctrl_debounce.sv
// Generic switch debouncer: registers the raw input, then only follows it after it has
// differed from the debounced value for DEBOUNCE_CYC consecutive cycles.
module alarm_debounce
   import alarm_chime_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
   parameter int unsigned CNT_W        = DefCntW
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic             din_q;
   logic             dout_q, dout_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;

   always_comb begin
      dout_d = dout_q;
      dcnt_d = '0;
      if (din_q != dout_q) begin
         if (dcnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            dout_d = din_q;
         end else begin
            dcnt_d = dcnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         din_q  <= 1'b0;
         dout_q <= 1'b0;
         dcnt_q <= '0;
      end else begin
         din_q  <= din;
         dout_q <= dout_d;
         dcnt_q <= dcnt_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/alarm_chime_ctrl.sv
// Debounces the car-warning alarm, lights the warning lamp and plays a bounded beep
// pattern on the buzzer that the driver can silence with mute.
module alarm_chime_ctrl
   import alarm_chime_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
   parameter int unsigned BEEP_ON_CYC  = DefBeepOnCyc,
   parameter int unsigned BEEP_OFF_CYC = DefBeepOffCyc,
   parameter int unsigned MAX_BEEPS    = DefMaxBeeps,
   parameter int unsigned CNT_W        = DefCntW
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               alarm_in,
   input  logic                               mute,
   output logic                               buzzer,
   output logic                               lamp,
   output logic [$clog2(MAX_BEEPS+1)-1:0]     beep_cnt
);

   localparam int unsigned BcW = $clog2(MAX_BEEPS + 1);

   chime_state_e     state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [BcW-1:0]   beep_cnt_q, beep_cnt_d;
   logic [BcW-1:0]   beep_inc;
   logic             buzzer_q, lamp_q;
   logic             alarm_deb;

   alarm_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
   ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (alarm_in),
      .dout (alarm_deb)
   );

   assign beep_inc = beep_cnt_q + BcW'(1);

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      beep_cnt_d = beep_cnt_q;
      unique case (state_q)
         StIdle: begin
            timer_d    = '0;
            beep_cnt_d = '0;
            if (alarm_deb) state_d = StBeepOn;
         end
         StBeepOn: begin
            if (!alarm_deb) begin
               state_d    = StIdle;
               timer_d    = '0;
               beep_cnt_d = '0;
            end else if (mute) begin
               // An interrupted beep is not counted.
               state_d = StHold;
               timer_d = '0;
            end else if (timer_q == CNT_W'(BEEP_ON_CYC - 1)) begin
               timer_d = '0;
               if (beep_cnt_q != BcW'(MAX_BEEPS)) beep_cnt_d = beep_inc;
               state_d = (beep_inc >= BcW'(MAX_BEEPS)) ? StHold : StBeepOff;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         StBeepOff: begin
            if (!alarm_deb) begin
               state_d    = StIdle;
               timer_d    = '0;
               beep_cnt_d = '0;
            end else if (mute) begin
               state_d = StHold;
               timer_d = '0;
            end else if (timer_q == CNT_W'(BEEP_OFF_CYC - 1)) begin
               timer_d = '0;
               state_d = StBeepOn;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         StHold: begin
            timer_d = '0;
            if (!alarm_deb) begin
               state_d    = StIdle;
               beep_cnt_d = '0;
            end
         end
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         beep_cnt_q <= '0;
         buzzer_q   <= 1'b0;
         lamp_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         beep_cnt_q <= beep_cnt_d;
         buzzer_q   <= (state_d == StBeepOn);
         lamp_q     <= (state_d != StIdle);
      end
   end

   assign buzzer   = buzzer_q;
   assign lamp     = lamp_q;
   assign beep_cnt = beep_cnt_q;

endmodule

// File: doc/alarm_chime_ctrl.md
Name: alarm_chime_ctrl

Overview:
Downstream consumer of the car-warning `Alarm` level, the combinational output of carWarning. It debounces the raw alarm and drives a dashboard warning lamp. It also drives a buzzer with a bounded on/off chime pattern, and a driver mute input silences the buzzer early. It sits between carWarning and the buzzer/lamp output pins.

Parameters:
DEBOUNCE_CYC, 4, consecutive stable cycles required before the debounced alarm changes (>=1)
BEEP_ON_CYC, 8, buzzer-high cycles per beep (>=1)
BEEP_OFF_CYC, 8, buzzer-low cycles between beeps (>=1)
MAX_BEEPS, 3, beeps per alarm episode before going silent (>=1)
CNT_W, 16, width of the debounce and phase timers; must hold max(DEBOUNCE_CYC, BEEP_ON_CYC, BEEP_OFF_CYC)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
alarm_in  in  1  raw Alarm from carWarning; asynchronous to intent, glitchy
mute  in  1  driver acknowledge; level sampled each cycle
buzzer  out  1  buzzer drive, registered
lamp  out  1  warning lamp, registered; high in any non-IDLE state
beep_cnt  out  $clog2(MAX_BEEPS+1)  completed beeps in the current episode

Behaviour:
- Reset (synchronous, active-high, one clk edge):
  - state=IDLE; buzzer=0, lamp=0, beep_cnt=0.
  - alarm_r=0, alarm_deb=0, all timers=0.
  - Reset asserted mid-operation aborts the episode at once.
- Input stage: alarm_r <= alarm_in every cycle.
- Debounce:
  - When alarm_r != alarm_deb, dcnt increments.
  - When the inputs still differ and dcnt==DEBOUNCE_CYC-1, alarm_deb <= alarm_r and dcnt <= 0.
  - When alarm_r == alarm_deb, dcnt <= 0.
  - Pulses shorter than DEBOUNCE_CYC cycles are ignored.
- Latency: alarm_in first sampled high at edge n gives alarm_deb=1 after edge n+DEBOUNCE_CYC, and buzzer=1 and lamp=1 after edge n+DEBOUNCE_CYC+1. Falling latency is identical.
- FSM states: IDLE, BEEP_ON, BEEP_OFF, HOLD.
  - IDLE: buzzer=0, lamp=0, beep_cnt=0. alarm_deb=1 -> BEEP_ON with timer=0 and beep_cnt=0.
  - BEEP_ON: buzzer=1, timer increments. At timer==BEEP_ON_CYC-1, beep_cnt++ and timer<=0; then go to HOLD if the new beep_cnt==MAX_BEEPS, else BEEP_OFF.
  - BEEP_OFF: buzzer=0, timer increments. At timer==BEEP_OFF_CYC-1 -> BEEP_ON with timer<=0.
  - HOLD: buzzer=0, lamp=1, beep_cnt held. Leaves only on alarm_deb=0.
- Priority in every non-IDLE state, highest first:
  1. alarm_deb==0 -> IDLE.
  2. mute==1 in BEEP_ON/BEEP_OFF -> HOLD.
  3. Timer expiry.
- Mute rules:
  - A beep interrupted by mute (including its final cycle) does not increment beep_cnt.
  - Mute is ignored in IDLE and HOLD.
  - Mute does not latch: a new episode after IDLE beeps again.
- Resulting output pattern:
  - Buzzer high exactly BEEP_ON_CYC cycles, low BEEP_OFF_CYC cycles; period = BEEP_ON_CYC+BEEP_OFF_CYC.
  - Exactly MAX_BEEPS pulses per uninterrupted episode.
  - beep_cnt saturates at MAX_BEEPS and never wraps.
- Alarm dropping mid-beep: the buzzer keeps its current pattern until alarm_deb falls, then goes to 0 the following cycle. There is no partial-beep stretching.
- All outputs are decoded from registered state or counters, so they are glitch-free.

Decomposition:
- Shared package/header alarm_chime_pkg holds:
  - the state encoding (IDLE=2'd0, BEEP_ON=2'd1, BEEP_OFF=2'd2, HOLD=2'd3);
  - the default timing constants.
- One sub-module, alarm_debounce (params DEBOUNCE_CYC, CNT_W; ports clk, rst, din, dout). It is reused later for the DoorClose, Ignition and SeatBelt switch inputs.
- The FSM, phase timer and beep counter stay in alarm_chime_ctrl.

Test Plan:
(All with default parameters.)
1. Reset release: rst=1 for 2 edges with alarm_in=1 -> all outputs 0 during reset. After release, buzzer=1 and lamp=1 from the 5th edge after alarm_in is first sampled.
2. Glitch reject: alarm_in=1 for 3 cycles, then 0 -> buzzer=0, lamp=0 and beep_cnt=0 throughout.
3. Full episode: alarm_in held high for 100 cycles:
   - buzzer gives 3 pulses of 8 high / 8 low; beep_cnt steps 1, 2, 3;
   - then HOLD with lamp=1, buzzer=0;
   - alarm_in to 0 -> lamp=0 and beep_cnt=0 five edges later.
4. Mute: mute pulsed for 1 cycle during beep 2 -> buzzer=0 on the next edge, lamp stays 1, beep_cnt stays 1, no further beeps.
5. Alarm drop mid-beep: alarm_in to 0 at the 3rd cycle of beep 1 -> buzzer stays high until debounce completes, then buzzer=0 and lamp=0 together; beep_cnt=0 (IDLE).
6. Reset mid-operation plus simultaneous events:
   - rst pulse during BEEP_OFF -> IDLE immediately.
   - Re-trigger restarts with beep_cnt=0 and a full 3-beep pattern.
   - alarm_deb falling in the same cycle as mute -> IDLE, not HOLD.
